// File: rtl/m_wishbone_regbank.sv
// Wishbone register bank: NREGS registers of DW bits with byte-lane writes,
// independent programmable read/write latencies and a flat export of all registers.
// Optional macro M_WBREGBANK_ERR_EN adds ERR_O, which terminates out-of-range accesses
// in place of ACK_O.
module m_wishbone_regbank #(
    parameter int unsigned NREGS        = 4,
    parameter int unsigned DW           = 32,
    parameter logic [31:0] INITVAL      = 32'hdeadbabe,
    parameter int unsigned WRITELATENCY = 0,
    parameter int unsigned READLATENCY  = 0,
    parameter logic [7:0]  FILLER       = 8'hd0,
    localparam int unsigned AW          = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int unsigned NB          = DW / 8
) (
    input  logic                CLK_I,
    input  logic                RST_N_I,
    input  logic [AW-1:0]       ADR_I,
    input  logic [DW-1:0]       DAT_I,
    input  logic                STB_I,
    input  logic                WE_I,
    input  logic [NB-1:0]       SEL_I,
    output logic [DW-1:0]       DAT_O,
    output logic                ACK_O,
`ifdef M_WBREGBANK_ERR_EN
    output logic                ERR_O,
`endif
    output logic [NREGS*DW-1:0] REGS_O
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] regs_q [NREGS];

    logic [3:0]    wr_lat;
    logic [3:0]    rd_lat;
    logic [3:0]    lat;
    logic          comb_term;
    logic          term;
    logic          in_range;
    logic          ack_int;
    logic          wr_en;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] filler_word;

    assign wr_lat      = 4'(WRITELATENCY);
    assign rd_lat      = 4'(READLATENCY);
    assign filler_word = {NB{FILLER}};

    // Only meaningful for non-power-of-two NREGS; otherwise every index is valid.
    assign in_range = (32'(ADR_I) < NREGS);

    // State and latency counter; reset aborts any transfer in flight.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a zero latency for the current direction terminates
    // combinationally from IDLE without leaving it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        comb_term = 1'b0;
        lat       = WE_I ? wr_lat : rd_lat;
        unique case (state_q)
            StIdle: begin
                if (STB_I) begin
                    if (lat == 4'd0) begin
                        comb_term = 1'b1;
                    end else begin
                        cnt_d = lat - 4'd1;
                        if (lat == 4'd1) begin
                            state_d = StAck;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                if (!STB_I) begin
                    // Master gave up: drop the transfer silently.
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = StAck;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign term = comb_term | (state_q == StAck);

`ifdef M_WBREGBANK_ERR_EN
    assign ack_int = term & in_range;
    assign ERR_O   = term & ~in_range;
`else
    assign ack_int = term;
`endif

    assign ACK_O = ack_int;
    assign wr_en = term & WE_I & in_range;

    // Read mux; an index past the last register matches nothing and reads as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (ADR_I == AW'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    assign DAT_O = ack_int ? rd_data : filler_word;

    // Register storage with per-byte write enables, committed on the terminating edge.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= DW'(INITVAL);
            end
        end else if (wr_en) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (ADR_I == AW'(i)) begin
                    for (int b = 0; b < int'(NB); b++) begin
                        if (SEL_I[b]) begin
                            regs_q[i][8*b +: 8] <= DAT_I[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < int'(NREGS); gi++) begin : g_regs_out
        assign REGS_O[gi*DW +: DW] = regs_q[gi];
    end

endmodule

// File: tb/tb_m_wishbone_regbank.sv
// Directed bench for m_wishbone_regbank: four instances with different latency and
// size settings share the clock, reset and bus inputs; each has its own strobe.
module tb_m_wishbone_regbank;

    localparam logic [31:0] INIT = 32'hdeadbabe;
    localparam logic [31:0] FILL = 32'hd0d0d0d0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        stb0 = 1'b0, stb1 = 1'b0, stb2 = 1'b0, stb3 = 1'b0;
    logic [31:0] dat_o0, dat_o1, dat_o2, dat_o3;
    logic        ack0, ack1, ack2, ack3;
    logic [127:0] regs0, regs1, regs2;
    logic [95:0]  regs3;
`ifdef M_WBREGBANK_ERR_EN
    logic        err0, err1, err2, err3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Zero latency both directions.
    m_wishbone_regbank #(.NREGS(4), .DW(32), .WRITELATENCY(0), .READLATENCY(0)) dut0 (
        .CLK_I(clk), .RST_N_I(rst_n), .ADR_I(adr), .DAT_I(dat_i), .STB_I(stb0), .WE_I(we),
        .SEL_I(sel), .DAT_O(dat_o0), .ACK_O(ack0),
`ifdef M_WBREGBANK_ERR_EN
        .ERR_O(err0),
`endif
        .REGS_O(regs0));

    // Write latency 3, read latency 2.
    m_wishbone_regbank #(.NREGS(4), .DW(32), .WRITELATENCY(3), .READLATENCY(2)) dut1 (
        .CLK_I(clk), .RST_N_I(rst_n), .ADR_I(adr), .DAT_I(dat_i), .STB_I(stb1), .WE_I(we),
        .SEL_I(sel), .DAT_O(dat_o1), .ACK_O(ack1),
`ifdef M_WBREGBANK_ERR_EN
        .ERR_O(err1),
`endif
        .REGS_O(regs1));

    // Write latency 5 for the reset-abort scenario.
    m_wishbone_regbank #(.NREGS(4), .DW(32), .WRITELATENCY(5), .READLATENCY(1)) dut2 (
        .CLK_I(clk), .RST_N_I(rst_n), .ADR_I(adr), .DAT_I(dat_i), .STB_I(stb2), .WE_I(we),
        .SEL_I(sel), .DAT_O(dat_o2), .ACK_O(ack2),
`ifdef M_WBREGBANK_ERR_EN
        .ERR_O(err2),
`endif
        .REGS_O(regs2));

    // Three registers, so index 3 is out of range.
    m_wishbone_regbank #(.NREGS(3), .DW(32), .WRITELATENCY(1), .READLATENCY(1)) dut3 (
        .CLK_I(clk), .RST_N_I(rst_n), .ADR_I(adr), .DAT_I(dat_i), .STB_I(stb3), .WE_I(we),
        .SEL_I(sel), .DAT_O(dat_o3), .ACK_O(ack3),
`ifdef M_WBREGBANK_ERR_EN
        .ERR_O(err3),
`endif
        .REGS_O(regs3));

    task automatic test_reset();
        logic [127:0] exp4;
        logic [95:0]  exp3;
        exp4 = {INIT, INIT, INIT, INIT};
        exp3 = {INIT, INIT, INIT};
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (regs0 !== exp4) begin n_err++; $display("FAIL reset_regs0: got %h want %h", regs0, exp4); end
        n_cmp++; if (regs3 !== exp3) begin n_err++; $display("FAIL reset_regs3: got %h want %h", regs3, exp3); end
        n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL reset_ack1: got %b want 0", ack1); end
        n_cmp++; if (dat_o1 !== FILL) begin n_err++; $display("FAIL reset_dat1: got %h want %h", dat_o1, FILL); end
        n_cmp++; if (dat_o0 !== FILL) begin n_err++; $display("FAIL reset_dat0: got %h want %h", dat_o0, FILL); end
    endtask

    task automatic test_zero_latency();
        logic [127:0] exp4;
        exp4 = {INIT, 32'hde22ba44, INIT, INIT};
        @(posedge clk); #1;
        adr = 2'd2; sel = 4'b0101; dat_i = 32'h11223344; we = 1'b1; stb0 = 1'b1;
        #1;
        n_cmp++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL zl_wr_ack: got %b want 1", ack0); end
        n_cmp++; if (dat_o0 !== INIT) begin n_err++; $display("FAIL zl_wr_dat: got %h want %h", dat_o0, INIT); end
        @(posedge clk); #1;
        n_cmp++; if (regs0[95:64] !== 32'hde22ba44) begin n_err++; $display("FAIL zl_wr_reg: got %h want de22ba44", regs0[95:64]); end
        we = 1'b0;
        #1;
        n_cmp++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL zl_rd_ack: got %b want 1", ack0); end
        n_cmp++; if (dat_o0 !== 32'hde22ba44) begin n_err++; $display("FAIL zl_rd_dat: got %h want de22ba44", dat_o0); end
        @(posedge clk); #1;
        stb0 = 1'b0;
        #1;
        n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL zl_idle_ack: got %b want 0", ack0); end
        n_cmp++; if (dat_o0 !== FILL) begin n_err++; $display("FAIL zl_idle_dat: got %h want %h", dat_o0, FILL); end
        n_cmp++; if (regs0 !== exp4) begin n_err++; $display("FAIL zl_regs: got %h want %h", regs0, exp4); end
    endtask

    task automatic test_write_latency();
        logic exp;
        @(posedge clk); #1;
        adr = 2'd1; sel = 4'hf; dat_i = 32'hcafef00d; we = 1'b1; stb1 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp = (c == 3) || (c == 7);
            n_cmp++; if (ack1 !== exp) begin n_err++; $display("FAIL wl3_ack c%0d: got %b want %b", c, ack1, exp); end
            if (c == 3) begin
                n_cmp++; if (regs1[63:32] !== INIT) begin n_err++; $display("FAIL wl3_reg_before: got %h want %h", regs1[63:32], INIT); end
            end
            if (c == 4) begin
                n_cmp++; if (regs1[63:32] !== 32'hcafef00d) begin n_err++; $display("FAIL wl3_reg_after: got %h want cafef00d", regs1[63:32]); end
            end
        end
        stb1 = 1'b0;
    endtask

    task automatic test_read_abort();
        logic        exp;
        logic [31:0] exp_d;
        @(posedge clk); #1;
        adr = 2'd1; we = 1'b0; stb1 = 1'b1;
        @(negedge clk);
        n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL rl2_c0_ack: got %b want 0", ack1); end
        @(posedge clk); #1;
        stb1 = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL rl2_abort_ack c%0d: got %b want 0", c, ack1); end
            n_cmp++; if (dat_o1 !== FILL) begin n_err++; $display("FAIL rl2_abort_dat c%0d: got %h want %h", c, dat_o1, FILL); end
        end
        @(posedge clk); #1;
        stb1 = 1'b1;
        for (int c = 4; c < 8; c++) begin
            @(negedge clk);
            exp   = (c == 6);
            exp_d = (c == 6) ? 32'hcafef00d : FILL;
            n_cmp++; if (ack1 !== exp) begin n_err++; $display("FAIL rl2_ack c%0d: got %b want %b", c, ack1, exp); end
            n_cmp++; if (dat_o1 !== exp_d) begin n_err++; $display("FAIL rl2_dat c%0d: got %h want %h", c, dat_o1, exp_d); end
            if (c == 6) stb1 = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        logic exp;
        @(posedge clk); #1;
        adr = 2'd0; sel = 4'hf; dat_i = 32'h12345678; we = 1'b1; stb2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ack2 !== 1'b0) begin n_err++; $display("FAIL rst_abort_ack: got %b want 0", ack2); end
        n_cmp++; if (regs2[31:0] !== INIT) begin n_err++; $display("FAIL rst_abort_reg: got %h want %h", regs2[31:0], INIT); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++; if (ack2 !== 1'b0) begin n_err++; $display("FAIL rst_hold_ack k%0d: got %b want 0", k, ack2); end
        end
        stb2 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stb2 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            exp = (c == 5);
            n_cmp++; if (ack2 !== exp) begin n_err++; $display("FAIL wl5_ack c%0d: got %b want %b", c, ack2, exp); end
            if (c == 5) begin
                n_cmp++; if (regs2[31:0] !== INIT) begin n_err++; $display("FAIL wl5_reg_before: got %h want %h", regs2[31:0], INIT); end
            end
            if (c == 6) begin
                n_cmp++; if (regs2[31:0] !== 32'h12345678) begin n_err++; $display("FAIL wl5_reg_after: got %h want 12345678", regs2[31:0]); end
                stb2 = 1'b0;
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [95:0] exp3;
        exp3 = {INIT, INIT, INIT};
        // Write to index 3 of a three-register bank.
        @(posedge clk); #1;
        adr = 2'd3; we = 1'b1; sel = 4'hf; dat_i = 32'hffffffff; stb3 = 1'b1;
        @(negedge clk);
        n_cmp++; if (ack3 !== 1'b0) begin n_err++; $display("FAIL oor_wr_c0_ack: got %b want 0", ack3); end
        @(negedge clk);
`ifdef M_WBREGBANK_ERR_EN
        n_cmp++; if (err3 !== 1'b1) begin n_err++; $display("FAIL oor_wr_err: got %b want 1", err3); end
        n_cmp++; if (ack3 !== 1'b0) begin n_err++; $display("FAIL oor_wr_ack: got %b want 0", ack3); end
`else
        n_cmp++; if (ack3 !== 1'b1) begin n_err++; $display("FAIL oor_wr_ack: got %b want 1", ack3); end
`endif
        stb3 = 1'b0;
        @(negedge clk);
        n_cmp++; if (regs3 !== exp3) begin n_err++; $display("FAIL oor_regs: got %h want %h", regs3, exp3); end
        n_cmp++; if (ack3 !== 1'b0) begin n_err++; $display("FAIL oor_idle_ack: got %b want 0", ack3); end
        // Read from index 3.
        @(posedge clk); #1;
        we = 1'b0; stb3 = 1'b1;
        @(negedge clk);
        n_cmp++; if (ack3 !== 1'b0) begin n_err++; $display("FAIL oor_rd_c0_ack: got %b want 0", ack3); end
        @(negedge clk);
`ifdef M_WBREGBANK_ERR_EN
        n_cmp++; if (err3 !== 1'b1) begin n_err++; $display("FAIL oor_rd_err: got %b want 1", err3); end
        n_cmp++; if (ack3 !== 1'b0) begin n_err++; $display("FAIL oor_rd_ack: got %b want 0", ack3); end
        n_cmp++; if (dat_o3 !== FILL) begin n_err++; $display("FAIL oor_rd_dat: got %h want %h", dat_o3, FILL); end
`else
        n_cmp++; if (ack3 !== 1'b1) begin n_err++; $display("FAIL oor_rd_ack: got %b want 1", ack3); end
        n_cmp++; if (dat_o3 !== 32'h0) begin n_err++; $display("FAIL oor_rd_dat: got %h want 0", dat_o3); end
`endif
        stb3 = 1'b0;
        // In-range read of the last register still works.
        @(posedge clk); #1;
        adr = 2'd2; stb3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (ack3 !== 1'b1) begin n_err++; $display("FAIL ir_rd_ack: got %b want 1", ack3); end
        n_cmp++; if (dat_o3 !== INIT) begin n_err++; $display("FAIL ir_rd_dat: got %h want %h", dat_o3, INIT); end
`ifdef M_WBREGBANK_ERR_EN
        n_cmp++; if (err3 !== 1'b0) begin n_err++; $display("FAIL ir_rd_err: got %b want 0", err3); end
`endif
        stb3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_write_latency();
        test_read_abort();
        test_reset_abort();
        test_out_of_range();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/m_wishbone_regbank.md
Name: m_wishbone_regbank

Overview:
- Parametrised successor to the single wishbone slave test register: a bank of NREGS registers, each DW bits wide, with byte-lane writes.
- Independent programmable read and write latencies, driven by a small handshake state machine.
- Used as a flexible wishbone target when testing midgetv bus behaviour: multiple addresses, wait states, aborted cycles and back-to-back block transfers.
- Register contents are also exported flat so a bench can check them without bus reads.

Parameters:
NREGS, 4, number of registers; 1..256
DW, 32, data width; multiple of 8
INITVAL, 32'hdeadbabe, reset value of every register; truncated or zero-extended to DW
WRITELATENCY, 0, cycles from first STB_I&WE_I cycle to ACK_O; 0..15
READLATENCY, 0, cycles from first STB_I&~WE_I cycle to ACK_O; 0..15
FILLER, 8'hd0, byte replicated on DAT_O whenever ACK_O is low

Ports:
CLK_I  in  1  clock, rising edge
RST_N_I  in  1  reset, asynchronous assert, active-low
ADR_I  in  AW=max(1,clog2(NREGS))  register (word) index
DAT_I  in  DW  write data
STB_I  in  1  strobe
WE_I  in  1  1=write, 0=read
SEL_I  in  DW/8  byte-lane enables
DAT_O  out  DW  read data
ACK_O  out  1  acknowledge
REGS_O  out  NREGS*DW  all registers; register i at bits [i*DW +: DW]
ERR_O  out  1  error; present only with M_WBREGBANK_ERR_EN

Behaviour:
- Reset (RST_N_I=0), asynchronous:
  - every register = INITVAL; state = IDLE; latency counter = 0
  - ACK_O=0 for latency>0; ERR_O=0
  - DAT_O = FILLER pattern, except in latency-0 combinational paths
  - Reset asserted mid-transfer aborts the transfer: no write, no ACK.
- Latency L: WRITELATENCY if WE_I=1, READLATENCY if WE_I=0. WE_I is sampled when leaving IDLE.
- L=0 for the current direction: ACK_O = STB_I combinationally, with no state change. A write commits on every clock edge where STB_I&WE_I. One transfer per cycle.
- L>0, FSM states IDLE, WAIT, ACK:
  - IDLE: STB_I=1 at the edge → counter loaded with L-1. Go to ACK if L=1, else to WAIT.
  - WAIT: counter decrements each cycle. When the counter reaches 1 → ACK. STB_I=0 at any edge → IDLE (abort: no write, no ACK).
  - ACK: ACK_O=1 for exactly one cycle. Next state is always IDLE.
  - Result: ACK_O is high in cycle L, counting the first STB cycle as cycle 0.
- Block transfers with L>0: STB_I held after ACK starts a new transfer from IDLE. The next ACK arrives L+1 cycles after the previous one. ACK_O is never high two consecutive cycles.
- Write: on the edge closing the ACK_O=1 cycle, lane b of register ADR_I takes DAT_I[8b+7:8b] where SEL_I[b]=1. Other lanes and registers are unchanged.
- Read: DAT_O = register ADR_I while ACK_O=1, else FILLER replicated. SEL_I is ignored for reads.
- Out-of-range address (ADR_I ≥ NREGS, non-power-of-two NREGS), without the optional feature:
  - ACK still given with normal latency
  - write ignored
  - read returns all zeros
- ADR_I, WE_I, SEL_I and DAT_I must be held stable by the master while STB_I is high. The bank uses the values present in the ACK cycle for data. Only WE_I is sampled at start, for latency.
- REGS_O is taken directly from the register flops and updates on the edge after a write.

Optional Feature:
- Macro: M_WBREGBANK_ERR_EN.
- When defined:
  - ERR_O port exists.
  - An out-of-range address terminates the transfer with ERR_O instead of ACK_O, using identical timing (combinational when L=0, one-cycle pulse in the ACK state when L>0).
  - No write occurs; DAT_O shows the FILLER pattern.
  - ACK_O and ERR_O are never both high.
- When undefined: no ERR_O port, and out-of-range behaves as described in Behaviour.

Test Plan:
- Reset release with NREGS=4, DW=32 → REGS_O = four copies of 32'hdeadbabe; ACK_O=0; DAT_O=32'hd0d0d0d0.
- WRITELATENCY=0, READLATENCY=0: write ADR=2, SEL=4'b0101, DAT=32'h11223344, then read ADR=2 → ACK_O high in the same cycle as STB; read returns 32'hde22ba44; other registers unchanged.
- WRITELATENCY=3: STB_I&WE_I held from cycle 0 → ACK_O only in cycle 3; register updates at the end of cycle 3; held STB gives the next ACK in cycle 7.
- READLATENCY=2: STB drops in cycle 1 → no ACK, DAT_O stays at FILLER. Re-strobe → ACK two cycles later with the correct data.
- Assert RST_N_I in WAIT of a WRITELATENCY=5 write → ACK_O immediately 0, register keeps INITVAL, FSM returns to IDLE after reset release.
- NREGS=3 with M_WBREGBANK_ERR_EN: access ADR=3 → ERR_O pulse with normal latency, ACK_O=0, REGS_O unchanged. Without the macro: ACK given, read returns 0.
